// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: fetch FSM states, primary opcodes and word width.
// The control decoder and its bench rely on the same opcode constants.
package mips_pkg;

  localparam int WORD_W = 32;

  typedef enum logic {
    FETCH,
    HOLD
  } fetch_state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  function automatic logic [5:0] opcodeOf(input logic [WORD_W-1:0] word);
    return word[31:26];
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port: single-word request/ready handshake.
interface instr_fetch_if;
  import mips_pkg::*;

  logic              imem_req;
  logic [WORD_W-1:0] imem_addr;
  logic              imem_ready;
  logic [WORD_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/instr_fetch_pc_next.sv
// Next-PC arithmetic: sequential pc+4 or beq target pc+4+(offset<<2), all modulo 2^32.
module pc_next
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] i_pc,
  input  logic              i_branch_taken,
  input  logic [WORD_W-1:0] i_branch_offset,
  output logic [WORD_W-1:0] o_pc_plus4,
  output logic [WORD_W-1:0] o_pc_next
);

  logic [WORD_W-1:0] w_offset_bytes;

  // Word offset to byte offset; the shift drops bits [31:30], so negative offsets wrap naturally.
  assign w_offset_bytes = i_branch_offset << 2;
  assign o_pc_plus4     = i_pc + WORD_W'(4);
  assign o_pc_next      = i_branch_taken ? (o_pc_plus4 + w_offset_bytes) : o_pc_plus4;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: holds the PC, reads one word per instruction from imem and keeps it
// in the instruction register until the execute side retires it.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  instr_fetch_if.master     imem,
  input  logic              instr_accept,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_offset,
  output logic [WORD_W-1:0] instr,
  output logic [5:0]        opcode,
  output logic              instr_valid,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_plus4
);

  fetch_state_t      r_state;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_instr;
  logic              r_req;
  logic              r_valid;
  logic [WORD_W-1:0] w_pc_plus4;
  logic [WORD_W-1:0] w_pc_next;

  pc_next u_pc_next (
    .i_pc            (r_pc),
    .i_branch_taken  (branch_taken),
    .i_branch_offset (branch_offset),
    .o_pc_plus4      (w_pc_plus4),
    .o_pc_next       (w_pc_next)
  );

  // r_req stays low for the first cycle out of reset, so a stale ready is never taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (r_req && imem.imem_ready) begin
            r_instr <= imem.imem_rdata;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= HOLD;
          end else begin
            r_req <= 1'b1;
          end
        end
        HOLD: begin
          if (instr_accept) begin
            r_pc    <= w_pc_next;
            r_req   <= 1'b1;
            r_valid <= 1'b0;
            r_state <= FETCH;
          end
        end
        default: begin
          r_state <= FETCH;
        end
      endcase
    end
  end

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_pc;
  assign instr          = r_instr;
  assign opcode         = opcodeOf(r_instr);
  assign instr_valid    = r_valid;
  assign pc             = r_pc;
  assign pc_plus4       = w_pc_plus4;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by random traffic, all checked
// against a transaction-level model of the fetch/retire protocol.
module tb_instr_fetch;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if bus ();
  instr_fetch_if busWrap ();

  logic        instrAccept, branchTaken;
  logic [31:0] branchOffset;
  logic [31:0] instr, pc, pcPlus4;
  logic [5:0]  opcode;
  logic        instrValid;

  logic [31:0] instrW, pcW, pcPlus4W;
  logic [5:0]  opcodeW;
  logic        instrValidW;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem(bus.master),
    .instr_accept(instrAccept), .branch_taken(branchTaken), .branch_offset(branchOffset),
    .instr(instr), .opcode(opcode), .instr_valid(instrValid), .pc(pc), .pc_plus4(pcPlus4)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clk(clk), .reset(reset), .imem(busWrap.master),
    .instr_accept(1'b1), .branch_taken(1'b0), .branch_offset(32'h0),
    .instr(instrW), .opcode(opcodeW), .instr_valid(instrValidW), .pc(pcW), .pc_plus4(pcPlus4W)
  );

  int totalChecks = 0;
  int badChecks = 0;

  // Reference model: PC, the held instruction word, and whether one is held / being requested.
  logic [31:0] mdlPc, mdlInstr;
  logic        mdlHeld, mdlReq;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic compareAll(input string tag);
    logic [31:0] word;
    word = mdlInstr;
    checkOutput({tag, ".req"},   {31'b0, bus.imem_req}, {31'b0, mdlReq});
    checkOutput({tag, ".addr"},  bus.imem_addr, mdlPc);
    checkOutput({tag, ".valid"}, {31'b0, instrValid}, {31'b0, mdlHeld});
    checkOutput({tag, ".instr"}, instr, mdlInstr);
    checkOutput({tag, ".op"},    {26'b0, opcode}, {26'b0, word[31:26]});
    checkOutput({tag, ".pc"},    pc, mdlPc);
    checkOutput({tag, ".pc4"},   pcPlus4, mdlPc + 32'd4);
  endtask

  task automatic applyStimulus(input logic ready, input logic [31:0] rdata, input logic accept,
                               input logic taken, input logic [31:0] offset, input string tag);
    bus.imem_ready = ready;
    bus.imem_rdata = rdata;
    instrAccept    = accept;
    branchTaken    = taken;
    branchOffset   = offset;
    if (mdlHeld) begin
      if (accept) begin
        mdlPc   = mdlPc + 32'd4 + (taken ? offset * 32'd4 : 32'd0);
        mdlHeld = 1'b0;
        mdlReq  = 1'b1;
      end
    end else if (mdlReq && ready) begin
      mdlInstr = rdata;
      mdlHeld  = 1'b1;
      mdlReq   = 1'b0;
    end else begin
      mdlReq = 1'b1;
    end
    @(posedge clk);
    #1;
    compareAll(tag);
  endtask

  // Reset is raised between edges so its effect is checked before any clock edge.
  task automatic doReset(input string tag);
    reset = 1'b1;
    #1;
    mdlPc    = 32'h0;
    mdlInstr = 32'h0;
    mdlHeld  = 1'b0;
    mdlReq   = 1'b0;
    compareAll({tag, ".async"});
    @(posedge clk);
    #1;
    compareAll({tag, ".held"});
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] rOffset;
    logic [31:0] frozenInstr;

    bus.imem_ready     = 1'b0;
    bus.imem_rdata     = 32'h0;
    busWrap.imem_ready = 1'b1;
    busWrap.imem_rdata = 32'hAC00_0000;
    instrAccept        = 1'b0;
    branchTaken        = 1'b0;
    branchOffset       = 32'h0;
    @(posedge clk);
    #1;
    doReset("reset");

    // Sequential fetch with zero-wait memory; the wrap instance runs in lockstep.
    applyStimulus(1'b1, 32'h8C01_0004, 1'b1, 1'b0, 32'h0, "seq1");
    checkOutput("seq.addr0", bus.imem_addr, 32'h0);
    checkOutput("wrap.req", {31'b0, busWrap.imem_req}, 32'h1);
    checkOutput("wrap.addr0", busWrap.imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 32'h8C01_0004, 1'b1, 1'b0, 32'h0, "seq2");
    checkOutput("seq.opcode", {26'b0, opcode}, {26'b0, OP_LW});
    checkOutput("wrap.valid", {31'b0, instrValidW}, 32'h1);
    checkOutput("wrap.opcode", {26'b0, opcodeW}, {26'b0, OP_SW});
    applyStimulus(1'b1, 32'h8C01_0004, 1'b1, 1'b0, 32'h0, "seq3");
    checkOutput("seq.addr4", bus.imem_addr, 32'h4);
    checkOutput("wrap.addr1", busWrap.imem_addr, 32'h0);
    checkOutput("wrap.pc4", pcPlus4W, 32'h4);
    checkOutput("wrap.instr", instrW, 32'hAC00_0000);
    applyStimulus(1'b1, 32'h8C01_0004, 1'b1, 1'b0, 32'h0, "seq4");
    applyStimulus(1'b1, 32'h8C01_0004, 1'b1, 1'b0, 32'h0, "seq5");
    checkOutput("seq.addr8", bus.imem_addr, 32'h8);

    // Wait states at pc 0x8.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h1234_5678, 1'b1, 1'b1, 32'h7, "wait");
      checkOutput("wait.addr", bus.imem_addr, 32'h8);
      checkOutput("wait.req", {31'b0, bus.imem_req}, 32'h1);
    end
    applyStimulus(1'b1, 32'h1000_0008, 1'b0, 1'b0, 32'h0, "waitDone");
    checkOutput("wait.valid", {31'b0, instrValid}, 32'h1);

    // Walk to 0x10, then taken branches forward and backward.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, "br0");
    applyStimulus(1'b1, 32'h1000_000C, 1'b0, 1'b0, 32'h0, "br1");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, "br2");
    applyStimulus(1'b1, 32'h1000_0010, 1'b0, 1'b0, 32'h0, "br3");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0003, "brFwd");
    checkOutput("br.fwd", bus.imem_addr, 32'h20);
    applyStimulus(1'b1, 32'h1000_0020, 1'b0, 1'b0, 32'h0, "br4");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFB, "brBack1");
    checkOutput("br.back1", bus.imem_addr, 32'h10);
    applyStimulus(1'b1, 32'h1000_0010, 1'b0, 1'b0, 32'h0, "br5");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFB, "brBack2");
    checkOutput("br.back2", bus.imem_addr, 32'h0);
    applyStimulus(1'b1, 32'h1000_0000, 1'b0, 1'b0, 32'h0, "br6");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0003, "br7");
    applyStimulus(1'b1, 32'h1000_0010, 1'b0, 1'b0, 32'h0, "br8");

    // Stall in HOLD with taken asserted but no accept.
    frozenInstr = instr;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, $urandom, 1'b0, 1'b1, $urandom, "stall");
      checkOutput("stall.pc", pc, 32'h10);
      checkOutput("stall.instr", instr, frozenInstr);
    end
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h0000_0055, "untaken");
    checkOutput("untaken.pc", pc, 32'h14);

    // Reach a pending fetch at 0x40, then reset with ready pulsing.
    applyStimulus(1'b1, 32'h1000_0014, 1'b0, 1'b0, 32'h0, "mid0");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_000A, "mid1");
    checkOutput("mid.addr", bus.imem_addr, 32'h40);
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    doReset("midReset");
    applyStimulus(1'b1, 32'h8C01_0004, 1'b0, 1'b0, 32'h0, "restart");
    checkOutput("restart.addr", bus.imem_addr, 32'h0);
    checkOutput("restart.req", {31'b0, bus.imem_req}, 32'h1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        doReset("rndReset");
      end else begin
        if ($urandom_range(0, 3) == 0) rOffset = $urandom;
        else rOffset = {{16{1'b0}}, 16'($urandom_range(0, 65535))};
        if (rOffset[15]) rOffset[31:16] = 16'hFFFF;
        applyStimulus($urandom_range(0, 9) < 7, $urandom, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), rOffset, "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
